// File: rtl/hs_sync_pkg.sv
// ============================================================================
// Module      : hs_sync_pkg
// Description : Shared FSM state encoding and synchroniser limits for the
//               req/ack receive-side controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hs_sync_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ACK   = 2'd2,
        ST_FLUSH = 2'd3
    } hs_state_e;

endpackage

`default_nettype wire

// File: rtl/multi_flop_sync.sv
// ============================================================================
// Module      : multi_flop_sync
// Description : Single-bit flop-chain synchroniser, synchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_flop_sync
    import hs_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // A depth below the metastability minimum is rounded up rather than honoured.
    localparam int STAGES = (NUM_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : NUM_STAGES;

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hs_sync_ctrl.sv
// ============================================================================
// Module      : hs_sync_ctrl
// Description : Destination-side four-phase req/ack controller presenting a
//               captured bus with valid/ready. Watchdog: define HS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_sync_ctrl
    import hs_sync_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 un_sync_req,
    input  logic [BUS_WIDTH-1:0] un_sync_bus,
    input  logic                 sync_ready,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 sync_valid,
    output logic                 req_ack,
    output logic                 busy,
    output logic                 hs_err
);

    hs_state_e            r_state;
    hs_state_e            w_next;
    logic                 w_req_s;
    logic [BUS_WIDTH-1:0] r_bus;
    logic                 r_valid;
    logic                 r_ack;
    logic                 r_busy;

    multi_flop_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk (CLK),
        .rst (RST),
        .d   (un_sync_req),
        .q   (w_req_s)
    );

`ifdef HS_TIMEOUT_EN
    localparam int                   TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_CNT_W-1:0]  TO_MAX   = TO_CNT_W'(TIMEOUT_CYCLES);

    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                r_err;

    // Counter sits at zero outside ACK, so it is effectively cleared on ACK entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != ST_ACK) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if ((r_state == ST_ACK) && (w_next == ST_FLUSH)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hs_err = r_err;
`else
    if (TIMEOUT_CYCLES < 0) begin : g_no_watchdog
    end

    assign hs_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_s)    w_next = ST_HOLD;
            ST_HOLD:  if (sync_ready) w_next = ST_ACK;
            ST_ACK: begin
                if (!w_req_s) begin
                    w_next = ST_IDLE;
                end
`ifdef HS_TIMEOUT_EN
                else if (r_to_cnt == TO_MAX) begin
                    w_next = ST_FLUSH;
                end
`endif
            end
            ST_FLUSH: if (!w_req_s)   w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next state and registered so req_ack cannot glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_bus   <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == ST_HOLD);
            r_ack   <= (w_next == ST_ACK);
            r_busy  <= (w_next != ST_IDLE);
            if ((r_state == ST_IDLE) && w_req_s) begin
                r_bus <= un_sync_bus;
            end
        end
    end

    assign sync_bus   = r_bus;
    assign sync_valid = r_valid;
    assign req_ack    = r_ack;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: doc/hs_sync_ctrl.md
# hs_sync_ctrl

Destination-domain controller for a four-phase req/ack handshake that moves a multi-bit bus across a clock boundary. It synchronises the incoming request through a flop chain, captures the quasi-static bus once, and presents it downstream with a valid/ready handshake. It returns an acknowledge that the source domain synchronises back. It sits on the receive side of every multi-bit crossing in the system, such as UART RX data into the register/ALU domain and configuration words into the TX domain.

## Interface
- BUS_WIDTH, 8, width of the crossed data bus
- NUM_STAGES, 2, synchroniser depth on un_sync_req; minimum 2
- TIMEOUT_CYCLES, 255, ACK-state watchdog limit; used only with HS_TIMEOUT_EN
- CLK  in  1  destination-domain clock
- RST  in  1  synchronous, active-high reset
- un_sync_req  in  1  request from source domain, asynchronous to CLK
- un_sync_bus  in  BUS_WIDTH  source data; source holds it stable from req rise until ack rise
- sync_ready  in  1  downstream accepts sync_bus
- sync_bus  out  BUS_WIDTH  captured data, registered
- sync_valid  out  1  sync_bus holds an unconsumed word
- req_ack  out  1  acknowledge to source domain, registered, glitch-free
- busy  out  1  FSM not in IDLE
- hs_err  out  1  sticky watchdog error; tied 0 without HS_TIMEOUT_EN

## Operation
- un_sync_req passes through an NUM_STAGES-flop chain; the last stage is req_s. No other input is synchronised.
- FSM states are IDLE, HOLD, ACK, and FLUSH. FLUSH exists only with HS_TIMEOUT_EN.
- IDLE: req_ack=0, sync_valid=0. If req_s=1, load sync_bus from un_sync_bus and go to HOLD.
- HOLD: sync_valid=1. If sync_ready=1, go to ACK. Otherwise stay, with sync_bus frozen.
- ACK: req_ack=1. If req_s=0, go to IDLE.
- FLUSH: req_ack=0. If req_s=0, go to IDLE.
- busy = (state != IDLE).
- sync_ready is ignored outside HOLD.
- If req drops during HOLD (protocol violation), stay in HOLD until accepted. Then ACK lasts exactly one cycle and the FSM returns to IDLE. There is no second capture.
- un_sync_bus changes while in HOLD or ACK have no effect on sync_bus.

## Timing
- Reset values: state=IDLE, all synchroniser flops 0, sync_bus=0, sync_valid=0, req_ack=0, busy=0, hs_err=0.
- Reset mid-handshake aborts the transfer and drops req_ack at the reset edge. If req is still high after reset, a fresh capture occurs.
- Let e0 be the first CLK edge that samples un_sync_req=1. sync_valid and busy rise at edge e0+NUM_STAGES, and sync_bus updates on the same edge.
- If sync_valid&sync_ready is sampled at edge k, sync_valid falls and req_ack rises at edge k. The minimum valid duration is one cycle.
- Let f0 be the first edge that samples un_sync_req=0 in ACK. req_ack and busy fall at edge f0+NUM_STAGES.
- Back-to-back transfers: a new req_s=1 is honoured only after the FSM returns to IDLE. There is at least one IDLE cycle between words.

## Configuration
- HS_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on ACK entry and increments each ACK cycle.
  - If req_s is still 1 when the count reaches TIMEOUT_CYCLES, the next edge moves the FSM to FLUSH, drops req_ack, and sets hs_err.
  - hs_err clears only on RST.
- HS_TIMEOUT_EN undefined:
  - No counter and no FLUSH state.
  - ACK waits indefinitely.
  - hs_err is constant 0.

## Structure
- Shared package hs_sync_pkg holds the state enum typedef (IDLE, HOLD, ACK, FLUSH; 2-bit encoding) and the minimum-stage constant (2).
- One sub-module: multi_flop_sync.
  - Parameter NUM_STAGES, 1-bit, synchronous active-high reset to 0.
  - Instantiated once, for un_sync_req.
- hs_sync_ctrl holds the FSM, capture register and optional watchdog.

## Test plan
- Basic transfer (NUM_STAGES=2): un_sync_bus=0xA5, req high before edge 0, sync_ready=1. Expect sync_valid and sync_bus=0xA5 at edge 2, req_ack rising at edge 3. Drop req; expect req_ack falling 2 edges later.
- Backpressure: sync_ready=0 for 10 cycles. Expect sync_valid held, sync_bus stable at 0x3C despite the bus changing to 0xFF, and req_ack=0. Raise ready; expect req_ack=1 on that edge.
- Back-to-back: 0x01, 0x02, 0x03, each launched when the source sees ack low. Expect exactly three valid/ready accepts in order and ≥1 IDLE cycle between them.
- Early req drop: req falls during HOLD. Expect a single accept, req_ack high exactly one cycle, then IDLE with no recapture.
- Reset mid-ACK: assert RST while req_ack=1. Expect all outputs 0 at the reset edge. Keep req high after reset; expect a recapture with sync_valid at edge NUM_STAGES after release.
- HS_TIMEOUT_EN, TIMEOUT_CYCLES=4: hold req high after ack. Expect FLUSH entry, req_ack=0 and hs_err=1. Drop req; expect IDLE with hs_err still 1.
